// File: rtl/mult_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM states, Booth pair
// codes and a constant-foldable ceil(log2) used to size the step counter.
package mult_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'b00,
    BOOTH_ADD = 2'b01,
    BOOTH_SUB = 2'b10
  } booth_op_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // {q0, q_1}: 01 adds the multiplicand, 10 subtracts it, 00/11 do nothing.
  function automatic booth_op_t booth_decode(input logic [1:0] pair);
    case (pair)
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract into the accumulator,
// then an arithmetic right shift of the whole {acc, q, q_1} register.
module booth_step
  import mult_pkg::*;
#(
  parameter int E = 33
) (
  input  logic [2*E:0] i_p,
  input  logic [E-1:0] i_ext_a,
  input  logic [E-1:0] i_a_neg,
  output logic [2*E:0] o_p_next
);

  logic [E-1:0] w_acc;
  logic [E-1:0] w_sum;

  always_comb begin
    w_acc = i_p[2*E:E+1];
    w_sum = w_acc;
    case (booth_decode(i_p[1:0]))
      BOOTH_ADD: w_sum = w_acc + i_ext_a;
      BOOTH_SUB: w_sum = w_acc + i_a_neg;
      default:   w_sum = w_acc;
    endcase
    // Shifting drops the old q_1 and replicates the new accumulator MSB.
    o_p_next = {w_sum[E-1], w_sum, i_p[E:1]};
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier: operands are extended to WIDTH+1 bits so a
// single signed datapath serves both signed and unsigned operations.
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] valueA,
  input  logic [WIDTH-1:0] valueB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mostSig,
  output logic [WIDTH-1:0] leastSig
);

  localparam int E  = WIDTH + 1;
  localparam int CW = clog2(E);

  // Handshake: start is accepted on a rising edge where busy=0; done is a
  // single-cycle pulse marking mostSig/leastSig as the new product.
  state_t         r_state;
  state_t         w_state_next;
  logic [CW-1:0]  r_count;
  logic [2*E:0]   r_p;
  logic [E-1:0]   r_ext_a;
  logic [E-1:0]   r_a_neg;
  logic           r_busy;
  logic           r_done;
  logic [WIDTH-1:0] r_most;
  logic [WIDTH-1:0] r_least;

  logic           w_accept;
  logic           w_last;
  logic [E-1:0]   w_ext_a;
  logic [E-1:0]   w_ext_b;
  logic [E-1:0]   w_a_neg;
  logic [2*E:0]   w_p_next;

  always_comb begin
    w_ext_a = {is_signed & valueA[WIDTH-1], valueA};
    w_ext_b = {is_signed & valueB[WIDTH-1], valueB};
    w_a_neg = -w_ext_a;
  end

  booth_step #(.E(E)) u_step (
    .i_p      (r_p),
    .i_ext_a  (r_ext_a),
    .i_a_neg  (r_a_neg),
    .o_p_next (w_p_next)
  );

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_RUN;
          w_accept     = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_count == CW'(E - 1)) begin
          w_state_next = ST_IDLE;
          w_last       = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_p     <= '0;
      r_ext_a <= '0;
      r_a_neg <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_most  <= '0;
      r_least <= '0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == ST_RUN);
      r_done  <= w_last;
      if (w_accept) begin
        r_p     <= {{E{1'b0}}, w_ext_b, 1'b0};
        r_ext_a <= w_ext_a;
        r_a_neg <= w_a_neg;
        r_count <= '0;
      end else if (r_state == ST_RUN) begin
        r_p     <= w_p_next;
        r_count <= w_last ? '0 : r_count + 1'b1;
        if (w_last) begin
          // The 2E-bit product sits in P[2E:1]; only its low 2*WIDTH bits matter.
          r_most  <= w_p_next[2*WIDTH:WIDTH+1];
          r_least <= w_p_next[WIDTH:1];
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign mostSig  = r_most;
  assign leastSig = r_least;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: a WIDTH=32 instance for the main checks and
// a WIDTH=8 instance for the narrow-width latency and result.
module tb_booth_mult_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] ms;
  logic [31:0] ls;

  logic        start8;
  logic        signed8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [7:0]  ms8;
  logic [7:0]  ls8;

  int n_tests;
  int n_fail;

  booth_mult_seq #(.WIDTH(32)) dut (
    .clock     (clk),
    .reset     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .valueA    (a),
    .valueB    (b),
    .busy      (busy),
    .done      (done),
    .mostSig   (ms),
    .leastSig  (ls)
  );

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clock     (clk),
    .reset     (rst_n),
    .start     (start8),
    .is_signed (signed8),
    .valueA    (a8),
    .valueB    (b8),
    .busy      (busy8),
    .done      (done8),
    .mostSig   (ms8),
    .leastSig  (ls8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference product: extend each operand to 64 bits and keep the low 64 bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] ex;
    logic [63:0] ey;
    ex = s ? {{32{x[31]}}, x} : {32'b0, x};
    ey = s ? {{32{y[31]}}, y} : {32'b0, y};
    return ex * ey;
  endfunction

  // Ticks until done rises, bounded; n is the number of edges taken.
  task automatic wait_done(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 60);
    check({tag, "_done_seen"}, {63'b0, done}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic s, input logic [63:0] exp);
    int n;
    start     = 1'b1;
    is_signed = s;
    a         = x;
    b         = y;
    tick();
    start = 1'b0;
    wait_done(tag, n);
    check({tag, "_latency"}, 64'(n), 64'd33);
    check({tag, "_product"}, {ms, ls}, exp);
    tick();
    check({tag, "_done_drop"}, {63'b0, done}, 64'd0);
  endtask

  initial begin
    int n;
    int n2;
    int pulses;
    logic [31:0] rx;
    logic [31:0] ry;
    logic        rs;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    a         = '0;
    b         = '0;
    start8    = 1'b0;
    signed8   = 1'b0;
    a8        = '0;
    b8        = '0;

    // Reset state, with start asserted to show reset wins.
    start = 1'b1;
    tick();
    tick();
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_out", {ms, ls}, 64'd0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();

    // Directed products.
    run_op("s_3x12", 32'd3, 32'd12, 1'b1, 64'h0000_0000_0000_0024);
    check("held_after_done", {ms, ls}, 64'h0000_0000_0000_0024);
    run_op("s_m7x5", 32'hFFFF_FFF9, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFDD);
    run_op("u_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    run_op("s_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    run_op("s_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    run_op("u_0xff", 32'h0, 32'hFFFF_FFFF, 1'b0, 64'h0);
    run_op("u_minx2", 32'h8000_0000, 32'd2, 1'b0, 64'h0000_0001_0000_0000);

    // Start mid-operation with new operands is ignored.
    start = 1'b1; is_signed = 1'b1; a = 32'd9; b = 32'hFFFF_FFFD;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("midop_busy", {63'b0, busy}, 64'd1);
    check("midop_out_held", {ms, ls}, 64'h0000_0001_0000_0000);
    start = 1'b1; is_signed = 1'b0; a = 32'd100; b = 32'd100;
    tick();
    start = 1'b0;
    wait_done("midop", n);
    check("midop_latency", 64'(n + 6), 64'd33);
    check("midop_product", {ms, ls}, 64'hFFFF_FFFF_FFFF_FFE5);
    tick();

    // Reset after ten steps aborts the operation.
    start = 1'b1; is_signed = 1'b0; a = 32'd6; b = 32'd7;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_out", {ms, ls}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);

    // Back-to-back with start held high.
    start = 1'b1; is_signed = 1'b1; a = 32'd11; b = 32'd13;
    tick();
    a = 32'hFFFF_FFFE; b = 32'd1000;
    wait_done("b2b0", n);
    check("b2b0_latency", 64'(n), 64'd33);
    check("b2b0_product", {ms, ls}, 64'd143);
    tick();
    check("b2b1_done_drop", {63'b0, done}, 64'd0);
    check("b2b1_busy", {63'b0, busy}, 64'd1);
    a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF;
    wait_done("b2b1", n2);
    check("b2b1_spacing", 64'(n2 + 1), 64'd34);
    check("b2b1_product", {ms, ls}, 64'hFFFF_FFFF_FFFF_F830);
    tick();
    start = 1'b0;
    wait_done("b2b2", n2);
    check("b2b2_spacing", 64'(n2 + 1), 64'd34);
    check("b2b2_product", {ms, ls}, 64'h3FFF_FFFF_0000_0001);
    tick();

    // Narrow instance.
    start8 = 1'b1; signed8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    tick();
    start8 = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done8 && n < 30);
    check("w8_u_latency", 64'(n), 64'd9);
    check("w8_u_product", {48'b0, ms8, ls8}, 64'hFE01);
    tick();
    start8 = 1'b1; signed8 = 1'b1; a8 = 8'h80; b8 = 8'h80;
    tick();
    start8 = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done8 && n < 30);
    check("w8_s_latency", 64'(n), 64'd9);
    check("w8_s_product", {48'b0, ms8, ls8}, 64'h4000);
    tick();

    // Random operand pairs against the 64-bit reference.
    for (int i = 0; i < 100; i++) begin
      rx = $urandom;
      ry = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i < 8) rx[31] = 1'b1;
      run_op("rand", rx, ry, rs, ref_mul(rx, ry, rs));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
